neuron_mac: RTL and testbench

Parametrised successor to the single-input perceptron: one neuron computing y = act(sum_i(x_i*w_i) + b) over N_INPUTS signed fixed-point inputs.
- One time-multiplexed multiplier, one product accumulated per cycle.
- Configurable fractional scaling, output saturation and ReLU.
- valid/ready handshakes on both sides, so it chains into DAE encoder/decoder layer controllers.

---
 rtl/nn_pkg.sv | 34 +++
 rtl/neuron_mac_act.sv | 42 ++++
 rtl/neuron_mac.sv | 109 ++++++++++
 tb/tb_neuron_mac.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath: FSM state encoding,
// leaky-ReLU slope and the standard shift/ReLU/saturate function.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int LEAKY_SHIFT = 3;

  // Wide enough for any accumulator these neurons build; callers keep the low data_w bits.
  localparam int CALC_W = 64;

  function automatic logic signed [CALC_W-1:0] sat_relu(
    input logic signed [CALC_W-1:0] acc,
    input int                       frac_bits,
    input int                       data_w
  );
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] pmax;
    s    = acc >>> frac_bits;
    pmax = ($signed(CALC_W'(1)) <<< (data_w - 1)) - $signed(CALC_W'(1));
    if (s[CALC_W-1])
      sat_relu = '0;
    else if (s > pmax)
      sat_relu = pmax;
    else
      sat_relu = s;
  endfunction

endpackage

// File: rtl/neuron_mac_act.sv
// Combinational fractional shift, activation and saturation of the accumulator.
// NEURON_MAC_LEAKY_RELU_EN selects a 1/8-slope leaky ReLU for negative sums.
module neuron_mac_act
  import nn_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 19
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] y
);

  logic signed [CALC_W-1:0] acc_ext;
  logic signed [CALC_W-1:0] act_res;
  logic                     unused_hi;

  assign acc_ext = {{(CALC_W-ACC_W){acc[ACC_W-1]}}, acc};

`ifdef NEURON_MAC_LEAKY_RELU_EN
  localparam logic signed [CALC_W-1:0] NEG_MIN = -($signed(CALC_W'(1)) <<< (DATA_W - 1));

  logic signed [CALC_W-1:0] s;
  logic signed [CALC_W-1:0] leaky;

  always_comb begin
    s     = acc_ext >>> FRAC_BITS;
    leaky = s >>> LEAKY_SHIFT;
    if (s[CALC_W-1])
      act_res = (leaky < NEG_MIN) ? NEG_MIN : leaky;
    else
      act_res = sat_relu(acc_ext, FRAC_BITS, DATA_W);
  end
`else
  assign act_res = sat_relu(acc_ext, FRAC_BITS, DATA_W);
`endif

  // Saturation guarantees the result fits in DATA_W; the upper bits are sign copies.
  assign y         = act_res[DATA_W-1:0];
  assign unused_hi = ^act_res[CALC_W-1:DATA_W];

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: y = act(sum x_i*w_i + b) with one multiplier reused over N_INPUTS cycles.
// Optional leaky ReLU via NEURON_MAC_LEAKY_RELU_EN (handled inside neuron_mac_act).
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*DATA_W-1:0]   x_vec,
  input  logic [N_INPUTS*DATA_W-1:0]   w_vec,
  input  logic [DATA_W-1:0]            bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            y,
  output logic                         busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until then, and y stays put while out_valid waits.

  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int VEC_W = N_INPUTS*DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_t state, state_next;

  logic [VEC_W-1:0]          x_r, w_r;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic signed [DATA_W-1:0]  x_cur, w_cur;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic [DATA_W-1:0]         act_y;

  assign x_cur    = x_r[idx*DATA_W +: DATA_W];
  assign w_cur    = w_r[idx*DATA_W +: DATA_W];
  assign prod     = x_cur * w_cur;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias arrives in output Q-format, so lift it to the products' scale before seeding acc.
  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)        state_next = ACC;
      ACC:  if (idx == LAST_IDX) state_next = ACT;
      ACT:                       state_next = DONE;
      DONE: if (out_ready)       state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == ACC) || (state == ACT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r <= '0;
      w_r <= '0;
      acc <= '0;
      idx <= '0;
      y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r <= x_vec;
            w_r <= w_vec;
            acc <= bias_ext;
            idx <= '0;
          end
        end
        ACC: begin
          acc <= acc + prod_ext;
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        ACT:     y <= act_y;
        default: ;
      endcase
    end
  end

  neuron_mac_act #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_act (
    .acc (acc),
    .y   (act_y)
  );

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: two instances (FRAC_BITS 0 and 4) share one stimulus
// stream; expected outputs are queued at accept and popped at output handshake.
module tb_neuron_mac;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int VW = N*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] x_vec = '0;
  logic [VW-1:0] w_vec = '0;
  logic [DW-1:0] bias = '0;
  logic          in_ready, out_valid, busy;
  logic          in_ready4, out_valid4, busy4;
  logic [DW-1:0] y, y4;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q4[$];

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_vec(x_vec), .w_vec(w_vec), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .busy(busy)
  );

  neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(4)) u_dut_q4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .x_vec(x_vec), .w_vec(w_vec), .bias(bias), .out_valid(out_valid4),
    .out_ready(out_ready), .y(y4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] model_y(input logic [VW-1:0] xv, input logic [VW-1:0] wv,
                                            input logic [DW-1:0] b, input int frac);
    int acc;
    int s;
    int l;
    acc = int'($signed(b)) <<< frac;
    for (int i = 0; i < N; i++)
      acc += int'($signed(xv[i*DW +: DW])) * int'($signed(wv[i*DW +: DW]));
    s = acc >>> frac;
    if (s < 0) begin
`ifdef NEURON_MAC_LEAKY_RELU_EN
      l = s >>> 3;
      if (l < -128) l = -128;
      return DW'(l);
`else
      l = 0;
      return DW'(l);
`endif
    end
    if (s > 127) return 8'd127;
    return DW'(s);
  endfunction

  function automatic logic [VW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("q4_valid_lockstep", {31'd0, out_valid4}, 32'd1);
      if (exp_q.size() == 0)
        check("unexpected_output", 32'd1, 32'd0);
      else
        check("y_frac0", {24'd0, y}, {24'd0, exp_q.pop_front()});
      if (exp_q4.size() == 0)
        check("unexpected_output_q4", 32'd1, 32'd0);
      else
        check("y_frac4", {24'd0, y4}, {24'd0, exp_q4.pop_front()});
    end
  end

  // All driver tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [VW-1:0] xv, input logic [VW-1:0] wv,
                      input logic [DW-1:0] b, input bit push);
    int budget;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    x_vec = xv; w_vec = wv; bias = b; in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(model_y(xv, wv, b, 0));
      exp_q4.push_back(model_y(xv, wv, b, 4));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_vec = $urandom; w_vec = $urandom; bias = DW'($urandom_range(0, 255));
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() > 0 || exp_q4.size() > 0) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain_empty", exp_q.size() + exp_q4.size(), 32'd0);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] held;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic sum with latency and return-to-idle checks.
    out_ready = 1'b1;
    send(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 8'd0, 1'b1);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_out(lat);
    check("latency", lat, 32'd5);
    check("y_basic_const", {24'd0, y}, 32'd10);
    @(posedge clk); #1;
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
    check("y_retained", {24'd0, y}, 32'd10);

    // ReLU / leaky, saturation, most-negative operands, Q-format scaling.
    send(pack4(10, 10, 10, 10), pack4(-1, -1, -1, -1), 8'd5, 1'b1);
    send(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), 8'd127, 1'b1);
    send(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 8'd0, 1'b1);
    send(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 8'h80, 1'b1);
    send(pack4(16, 32, 0, 0), pack4(32, 16, 0, 0), 8'd16, 1'b1);
    drain();

    for (int i = 0; i < 12; i++)
      send(VW'($urandom), VW'($urandom), DW'($urandom_range(0, 255)), 1'b1);
    drain();

    // Backpressure: output held, new requests ignored, single handshake.
    out_ready = 1'b0;
    send(pack4(3, 4, 5, 6), pack4(2, 2, 2, 2), 8'd1, 1'b1);
    wait_out(lat);
    held = y;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      x_vec = $urandom; w_vec = $urandom;
      @(posedge clk); #1;
      check("bp_y_stable", {24'd0, y}, {24'd0, held});
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_single_hs", {31'd0, out_valid}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_no_ghost_accept", {31'd0, busy}, 32'd0);
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // Reset in the middle of accumulation.
    send(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 8'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_mid_acc", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_y", {24'd0, y}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    send(pack4(2, -3, 4, 1), pack4(5, 1, 2, 7), 8'd3, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
